uart_rx_deframer: RTL and testbench

- Asynchronous 8N1 serial receiver that sits directly upstream of the ANSI escape translator.
- Synchronises the raw rx pin, detects and validates the start bit, and samples 8 data bits LSB-first using a 3-sample majority vote at mid-bit.
- Checks the stop bit.
- Good bytes are delivered as a one-cycle valid pulse plus data, which feed the translator's byte-in/valid-in pair. Bad stop bits raise a framing-error pulse instead.

---
 rtl/uart_rx_deframer_pkg.sv | 36 +++
 rtl/uart_rx_deframer_sync_2ff.sv | 35 +++
 rtl/uart_rx_deframer.sv | 142 ++++++++++++++
 tb/tb_uart_rx_deframer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deframer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_rx_deframer_pkg
// Purpose  : Shared definitions for the 8N1 receive deframer: FSM state
//            encodings, bit-timing derivation helpers and the majority vote.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package uart_rx_deframer_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rxState_t;

   // Below this the three mid-bit samples would crowd the bit edges.
   localparam int c_MIN_CLKS_PER_BIT = 8;

   // Truncating division: the timer runs slightly fast, never slow.
   function automatic int clksPerBit(input int clkFreq, input int baud);
      return clkFreq / baud;
   endfunction

   function automatic int halfBit(input int clks);
      return clks / 2;
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deframer_sync_2ff.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for an asynchronous, idle-high input line.
//            Resets to 1 so an idle line is never mistaken for activity.
// Ports    : clk      - system clock
//            resetn   - asynchronous active-low reset
//            asyncIn  - raw asynchronous input
//            syncOut  - synchronised copy, 2-cycle latency
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic resetn,
   input  logic asyncIn,
   output logic syncOut
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= asyncIn;
         r_sync <= r_meta;
      end
   end

   assign syncOut = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_rx_deframer
// Purpose  : 8N1 asynchronous serial receiver. Synchronises rxPin, validates
//            the start bit, samples each bit with a 3-sample mid-bit majority
//            vote and checks the stop bit.
// Ports    : clk            - system clock
//            resetn         - asynchronous active-low reset
//            rxPin          - raw serial line, idle high
//            rxDataOutValid - one-cycle pulse, rxDataOut holds a new byte
//            rxDataOut      - last good byte, held until the next one
//            rxFramingError - one-cycle pulse, stop bit sampled low
//            rxBusy         - high whenever the FSM is not in IDLE
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_rx_deframer
   import uart_rx_deframer_pkg::*;
#(
   parameter int CLK_FREQ = 27000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rxPin,
   output logic       rxDataOutValid,
   output logic [7:0] rxDataOut,
   output logic       rxFramingError,
   output logic       rxBusy
);

   localparam int c_CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);
   localparam int c_HALF         = halfBit(c_CLKS_PER_BIT);
   localparam int c_TW           = $clog2(c_CLKS_PER_BIT);

   localparam logic [c_TW-1:0] c_T_LAST = c_TW'(c_CLKS_PER_BIT - 1);
   localparam logic [c_TW-1:0] c_T_S0   = c_TW'(c_HALF - 1);
   localparam logic [c_TW-1:0] c_T_S1   = c_TW'(c_HALF);
   localparam logic [c_TW-1:0] c_T_DEC  = c_TW'(c_HALF + 1);

   generate
      if (c_CLKS_PER_BIT < c_MIN_CLKS_PER_BIT) begin : g_badBitRate
         $error("uart_rx_deframer: CLK_FREQ/BAUD must be at least 8");
      end
   endgenerate

   rxState_t        r_state;
   logic [c_TW-1:0] r_timer;
   logic [2:0]      r_bitIdx;
   logic [7:0]      r_shift;
   logic            r_samp0;
   logic            r_samp1;
   logic [7:0]      r_dataOut;
   logic            r_valid;
   logic            r_ferr;

   logic w_syncRx;
   logic w_timerWrap;
   logic w_decide;
   logic w_majority;

   sync_2ff u_sync (
      .clk     (clk),
      .resetn  (resetn),
      .asyncIn (rxPin),
      .syncOut (w_syncRx)
   );

   assign w_timerWrap = (r_timer == c_T_LAST);
   assign w_decide    = (r_timer == c_T_DEC);
   // Third vote is the live sample taken on the decision cycle itself.
   assign w_majority  = majority3(r_samp0, r_samp1, w_syncRx);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= WAIT_IDLE;
         r_timer   <= '0;
         r_bitIdx  <= '0;
         r_shift   <= '0;
         r_samp0   <= 1'b1;
         r_samp1   <= 1'b1;
         r_dataOut <= 8'h00;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;

         if (r_timer == c_T_S0) r_samp0 <= w_syncRx;
         if (r_timer == c_T_S1) r_samp1 <= w_syncRx;

         case (r_state)
            WAIT_IDLE: begin
               r_timer <= '0;
               if (w_syncRx) r_state <= IDLE;
            end
            IDLE: begin
               r_timer <= '0;
               if (!w_syncRx) r_state <= START;
            end
            START: begin
               r_timer <= w_timerWrap ? '0 : r_timer + c_TW'(1);
               if (w_decide && w_majority) begin
                  r_state <= IDLE;              // false start: glitch on idle line
               end else if (w_timerWrap) begin
                  r_state  <= DATA;
                  r_bitIdx <= '0;
               end
            end
            DATA: begin
               r_timer <= w_timerWrap ? '0 : r_timer + c_TW'(1);
               if (w_decide) r_shift <= {w_majority, r_shift[7:1]};
               if (w_timerWrap) begin
                  r_bitIdx <= r_bitIdx + 3'd1;
                  if (r_bitIdx == 3'd7) r_state <= STOP;
               end
            end
            STOP: begin
               r_timer <= w_timerWrap ? '0 : r_timer + c_TW'(1);
               // Leave at mid stop bit so a back-to-back start edge is not missed.
               if (w_decide) begin
                  if (w_majority) begin
                     r_dataOut <= r_shift;
                     r_valid   <= 1'b1;
                     r_state   <= IDLE;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= WAIT_IDLE;      // sit out a break until line idles
                  end
               end
            end
            default: r_state <= WAIT_IDLE;
         endcase
      end
   end

   assign rxDataOutValid = r_valid;
   assign rxDataOut      = r_dataOut;
   assign rxFramingError = r_ferr;
   assign rxBusy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_deframer
// Purpose  : Self-checking bench for uart_rx_deframer at 16 clocks per bit.
//            Expected bytes are queued as frames are sent and popped when the
//            receiver pulses rxDataOutValid.
// Ports    : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_rx_deframer;

   localparam int CLK_FREQ = 1600000;
   localparam int BAUD     = 100000;

   logic       clk    = 1'b0;
   logic       resetn = 1'b0;
   logic       rxPin  = 1'b1;
   logic       rxDataOutValid;
   logic [7:0] rxDataOut;
   logic       rxFramingError;
   logic       rxBusy;

   uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .rxPin          (rxPin),
      .rxDataOutValid (rxDataOutValid),
      .rxDataOut      (rxDataOut),
      .rxFramingError (rxFramingError),
      .rxBusy         (rxBusy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] expQ[$];
   int         validTimes[$];
   int         errTimes[$];
   logic [7:0] expHeld = 8'h00;   // value rxDataOut should be holding

   // Drive one 8N1 frame (160 cycles). spikeAt inverts the line for the
   // single frame cycle given; nCycles < 160 truncates the frame.
   task automatic send_frame(input logic [7:0] b, input logic stopVal,
                             input int spikeAt, input int nCycles,
                             output int startCyc);
      logic lvl;
      startCyc = 0;
      for (int j = 0; j < nCycles; j++) begin
         @(negedge clk);
         if (j == 0) startCyc = cyc;
         if (j < 16)       lvl = 1'b0;
         else if (j < 144) lvl = b[(j - 16) / 16];
         else              lvl = stopVal;
         if (j == spikeAt) lvl = ~lvl;
         rxPin = lvl;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rxPin = 1'b1;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++;
      if (rxDataOutValid !== 1'b0 || rxFramingError !== 1'b0 || rxDataOut !== 8'h00 || rxBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b e=%b d=%h busy=%b, need v=0 e=0 d=00 busy=1",
                  rxDataOutValid, rxFramingError, rxDataOut, rxBusy);
      end
      @(negedge clk) resetn = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (rxBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle_busy: got %b, need 0", rxBusy);
      end
   endtask

   task automatic test_basic;
      int c0, nv, ne;
      nv = validTimes.size(); ne = errTimes.size();
      expQ.push_back(8'h41); expHeld = 8'h41;
      send_frame(8'h41, 1'b1, -1, 160, c0);
      idle(6);
      vectors++;
      if (validTimes.size() != nv + 1 || errTimes.size() != ne) begin
         miscompares++;
         $display("FAIL basic_pulses: got valid=%0d err=%0d, need valid=1 err=0",
                  validTimes.size() - nv, errTimes.size() - ne);
      end else begin
         vectors++;
         if (validTimes[nv] - c0 != 157) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles, need 157", validTimes[nv] - c0);
         end
      end
   endtask

   task automatic test_framing;
      int c0, nv, ne, d0;
      nv = validTimes.size(); ne = errTimes.size();
      send_frame(8'h55, 1'b0, -1, 160, c0);
      repeat (40) @(negedge clk) rxPin = 1'b0;
      vectors++;
      if (errTimes.size() != ne + 1 || validTimes.size() != nv) begin
         miscompares++;
         $display("FAIL framing_pulses: got err=%0d valid=%0d, need err=1 valid=0",
                  errTimes.size() - ne, validTimes.size() - nv);
      end else begin
         vectors++;
         if (errTimes[ne] - c0 != 157) begin
            miscompares++;
            $display("FAIL framing_latency: got %0d cycles, need 157", errTimes[ne] - c0);
         end
      end
      vectors++;
      if (rxDataOut !== expHeld) begin
         miscompares++;
         $display("FAIL framing_data_held: got %h, need %h", rxDataOut, expHeld);
      end
      vectors++;
      if (rxBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL framing_break_busy: got %b, need 1", rxBusy);
      end
      @(negedge clk) rxPin = 1'b1;
      d0 = cyc;
      while (cyc < d0 + 4) @(negedge clk);
      vectors++;
      if (rxBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL framing_release_busy: got %b, need 0", rxBusy);
      end
      idle(10);
   endtask

   task automatic test_glitch;
      int c0, nv, ne;
      nv = validTimes.size(); ne = errTimes.size();
      @(negedge clk) rxPin = 1'b0;
      c0 = cyc;
      repeat (4) @(negedge clk);
      vectors++;
      if (rxBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_busy_rise: got %b, need 1", rxBusy);
      end
      @(negedge clk) rxPin = 1'b1;
      while (cyc < c0 + 12) @(negedge clk);
      vectors++;
      if (rxBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_busy_hold: got %b, need 1", rxBusy);
      end
      @(negedge clk);
      vectors++;
      if (rxBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_busy_drop: got %b, need 0", rxBusy);
      end
      idle(20);
      vectors++;
      if (validTimes.size() != nv || errTimes.size() != ne) begin
         miscompares++;
         $display("FAIL glitch_no_pulse: got valid=%0d err=%0d, need 0 0",
                  validTimes.size() - nv, errTimes.size() - ne);
      end
      expQ.push_back(8'h7E); expHeld = 8'h7E;
      send_frame(8'h7E, 1'b1, -1, 160, c0);
      idle(6);
      vectors++;
      if (validTimes.size() != nv + 1) begin
         miscompares++;
         $display("FAIL glitch_next_byte: got %0d valid pulses, need 1", validTimes.size() - nv);
      end
   endtask

   task automatic test_back_to_back;
      int c0, nv;
      logic [7:0] bytes [3];
      bytes[0] = 8'h1B; bytes[1] = 8'h5B; bytes[2] = 8'h41;
      nv = validTimes.size();
      for (int k = 0; k < 3; k++) begin
         expQ.push_back(bytes[k]);
         send_frame(bytes[k], 1'b1, -1, 160, c0);
      end
      expHeld = 8'h41;
      idle(6);
      vectors++;
      if (validTimes.size() != nv + 3) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d valid pulses, need 3", validTimes.size() - nv);
      end else begin
         for (int k = 1; k < 3; k++) begin
            vectors++;
            if (validTimes[nv + k] - validTimes[nv + k - 1] != 160) begin
               miscompares++;
               $display("FAIL b2b_spacing%0d: got %0d cycles, need 160", k,
                        validTimes[nv + k] - validTimes[nv + k - 1]);
            end
         end
      end
   endtask

   task automatic test_spike;
      int c0, nv;
      nv = validTimes.size();
      expQ.push_back(8'hA5); expHeld = 8'hA5;
      // Data bit 2, at the cycle the receiver's timer reads HALF.
      send_frame(8'hA5, 1'b1, 16 * 3 + 9, 160, c0);
      idle(6);
      vectors++;
      if (validTimes.size() != nv + 1 || rxDataOut !== 8'hA5) begin
         miscompares++;
         $display("FAIL spike_vote: got %0d pulses data=%h, need 1 pulse data=a5",
                  validTimes.size() - nv, rxDataOut);
      end
   endtask

   task automatic test_reset_abort;
      int c0, nv, ne;
      nv = validTimes.size(); ne = errTimes.size();
      send_frame(8'h99, 1'b1, -1, 16 * 5 + 6, c0);   // stop inside data bit 4
      @(negedge clk);
      resetn = 1'b0;
      #1;
      vectors++;
      if (rxDataOutValid !== 1'b0 || rxFramingError !== 1'b0 || rxDataOut !== 8'h00 || rxBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_reset_state: got v=%b e=%b d=%h busy=%b, need v=0 e=0 d=00 busy=1",
                  rxDataOutValid, rxFramingError, rxDataOut, rxBusy);
      end
      rxPin = 1'b1;
      expHeld = 8'h00;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (rxBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_busy_drop: got %b, need 0", rxBusy);
      end
      idle(100);
      vectors++;
      if (validTimes.size() != nv || errTimes.size() != ne || rxDataOut !== expHeld) begin
         miscompares++;
         $display("FAIL abort_no_pulse: got valid=%0d err=%0d data=%h, need 0 0 00",
                  validTimes.size() - nv, errTimes.size() - ne, rxDataOut);
      end
      expQ.push_back(8'h30); expHeld = 8'h30;
      send_frame(8'h30, 1'b1, -1, 160, c0);
      idle(6);
      vectors++;
      if (validTimes.size() != nv + 1) begin
         miscompares++;
         $display("FAIL abort_next_byte: got %0d valid pulses, need 1", validTimes.size() - nv);
      end
   endtask

   initial begin
      fork
         // Scoreboard monitor: pops the expected byte on every valid pulse.
         begin
            logic prevV, prevE;
            logic [7:0] exp;
            prevV = 1'b0; prevE = 1'b0;
            forever begin
               @(negedge clk);
               if (rxDataOutValid || rxFramingError) begin
                  vectors++;
                  if ((rxDataOutValid && rxFramingError) || (rxDataOutValid && prevV) || (rxFramingError && prevE)) begin
                     miscompares++;
                     $display("FAIL pulse_shape: got v=%b e=%b prev v=%b e=%b, need single exclusive pulses",
                              rxDataOutValid, rxFramingError, prevV, prevE);
                  end
               end
               if (rxDataOutValid) begin
                  validTimes.push_back(cyc);
                  vectors++;
                  if (expQ.size() == 0) begin
                     miscompares++;
                     $display("FAIL unexpected_valid: got data=%h, need no pulse", rxDataOut);
                  end else begin
                     exp = expQ.pop_front();
                     if (rxDataOut !== exp) begin
                        miscompares++;
                        $display("FAIL rx_byte: got %h, need %h", rxDataOut, exp);
                     end
                  end
               end
               if (rxFramingError) errTimes.push_back(cyc);
               prevV = rxDataOutValid;
               prevE = rxFramingError;
            end
         end
      join_none

      test_reset();
      test_basic();
      test_framing();
      test_glitch();
      test_back_to_back();
      test_spike();
      test_reset_abort();

      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d bytes undelivered, need 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
